// File: rtl/banco_fifos_umbral.sv
// Bank of independent per-lane synchronous FIFOs with threshold-based almost flags
// and sticky overflow/underflow error bits.
module banco_fifos_umbral #(
  parameter int unsigned NUM_FIFOS = 8,
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    bajo,
  input  logic [7:0]                    alto,
  input  logic [NUM_FIFOS-1:0]          push,
  input  logic [NUM_FIFOS*DATA_W-1:0]   data_in,
  input  logic [NUM_FIFOS-1:0]          pop,
  output logic [NUM_FIFOS*DATA_W-1:0]   data_out,
  output logic [NUM_FIFOS-1:0]          valid_out,
  output logic [NUM_FIFOS-1:0]          empty_fifos,
  output logic [NUM_FIFOS-1:0]          full_fifos,
  output logic [NUM_FIFOS-1:0]          almost_empty,
  output logic [NUM_FIFOS-1:0]          almost_full,
  output logic [NUM_FIFOS-1:0]          error_fifos
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = ADDR_W + 1;

  for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_lane
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              full, empty, push_ok, pop_ok;
    logic [7:0]        count_ext;

    always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == CntW'(Depth));
      pop_ok    = pop[gi] && !empty;
      // A full FIFO still takes a push when a pop frees the slot in the same cycle.
      push_ok   = push[gi] && (!full || pop[gi]);
      count_ext = 8'(count_q);
    end

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      valid_d  = pop_ok;
      err_d    = err_q | (push[gi] && full && !pop[gi]) | (pop[gi] && empty);
      if (push_ok) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        dout_q   <= '0;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        dout_q   <= dout_d;
        valid_q  <= valid_d;
        err_q    <= err_d;
      end
    end

    // Storage is deliberately left out of reset; the pointers alone define contents.
    always_ff @(posedge clk) begin
      if (reset && push_ok) begin
        mem_q[wr_ptr_q] <= data_in[gi*DATA_W +: DATA_W];
      end
    end

    assign data_out[gi*DATA_W +: DATA_W] = dout_q;
    assign valid_out[gi]    = valid_q;
    assign empty_fifos[gi]  = empty;
    assign full_fifos[gi]   = full;
    assign almost_empty[gi] = (count_ext <= bajo);
    assign almost_full[gi]  = (count_ext >= alto);
    assign error_fifos[gi]  = err_q;
  end

endmodule
